// File: rtl/instr_decode_stage.sv
// Instruction-decode stage for a 5-stage MIPS pipeline.
// Holds the architectural register file, decodes the IF/ID slot, reads the
// operands (bypassing a same-cycle write-back), extends the immediate,
// forms the branch and jump targets, and registers the result into the
// ID/EX slot. Load-use hazards insert a single bubble; downstream stall and
// flush control whether the slot advances.
module instr_decode_stage #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_4,
  output logic              id_ready,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_br_target,
  output logic [DATA_W-1:0] ex_jump_dest
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DATA_W-1:0] regFile [NUM_REGS];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [AW-1:0]     rsIdx;
  logic [AW-1:0]     rtIdx;
  logic [AW-1:0]     rdIdx;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] brTarget;
  logic [DATA_W-1:0] jumpDest;
  logic              usesRt;
  logic              loadUseHazard;

  // Field extraction; register indices keep only the low AW bits.
  always_comb begin
    opcode = instr[31:26];
    funct  = instr[5:0];
    rsIdx  = instr[21 +: AW];
    rtIdx  = instr[16 +: AW];
    rdIdx  = instr[11 +: AW];
  end

  // Register file write port; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile[i] <= '0;
      end
    end else if (wb_we && (wb_addr != '0)) begin
      regFile[wb_addr] <= wb_data;
    end
  end

  // Operand reads, with write-back data bypassed when it targets the same register.
  always_comb begin
    readData1 = regFile[rsIdx];
    readData2 = regFile[rtIdx];
    if (wb_we && (wb_addr == rsIdx)) begin
      readData1 = wb_data;
    end
    if (wb_we && (wb_addr == rtIdx)) begin
      readData2 = wb_data;
    end
    if (rsIdx == '0) begin
      readData1 = '0;
    end
    if (rtIdx == '0) begin
      readData2 = '0;
    end
  end

  // Immediate extension: logical immediates are zero-extended, all others sign-extended.
  always_comb begin
    immExt = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
      immExt = {{(DATA_W-16){1'b0}}, instr[15:0]};
    end
  end

  // Branch and jump targets; the adder wraps naturally at DATA_W bits.
  always_comb begin
    brTarget = pc_4 + (immExt << 2);
    jumpDest = {pc_4[DATA_W-1:28], instr[25:0], 2'b00};
  end

  // Load-use detection against the load currently sitting in ID/EX.
  always_comb begin
    usesRt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
             (opcode == OP_BEQ)   || (opcode == OP_BNE);
    loadUseHazard = 1'b0;
    if (id_valid && ex_valid && (ex_opcode == OP_LW) && (ex_rt != '0)) begin
      loadUseHazard = (ex_rt == rsIdx) || (usesRt && (ex_rt == rtIdx));
    end
  end

  // Flush always lets the slot drain; otherwise a stall or a hazard holds IF.
  assign id_ready = flush || (!ex_stall && !loadUseHazard);

  // ID/EX slot update in priority order: flush, stall, hazard bubble, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_br_target <= '0;
      ex_jump_dest <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (loadUseHazard) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_opcode    <= opcode;
      ex_funct     <= funct;
      ex_rs        <= rsIdx;
      ex_rt        <= rtIdx;
      ex_rd        <= rdIdx;
      ex_rdata1    <= readData1;
      ex_rdata2    <= readData2;
      ex_imm       <= immExt;
      ex_br_target <= brTarget;
      ex_jump_dest <= jumpDest;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage. Expected ID/EX contents are
// pushed to a scoreboard queue when an instruction is driven and popped when
// the slot updates one cycle later.
module tb_instr_decode_stage;

  localparam int DATA_W = 32;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [31:0]       instr = '0;
  logic [DATA_W-1:0] pc_4 = '0;
  logic              id_ready;
  logic              wb_we = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              ex_stall = 1'b0;
  logic              flush = 1'b0;
  logic              ex_valid;
  logic [5:0]        ex_opcode;
  logic [5:0]        ex_funct;
  logic [AW-1:0]     ex_rs;
  logic [AW-1:0]     ex_rt;
  logic [AW-1:0]     ex_rd;
  logic [DATA_W-1:0] ex_rdata1;
  logic [DATA_W-1:0] ex_rdata2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_br_target;
  logic [DATA_W-1:0] ex_jump_dest;

  typedef struct {
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] jmp;
  } expT;

  expT         sbq[$];
  logic [31:0] regModel [32];
  int          nChecks = 0;
  int          nErrors = 0;

  instr_decode_stage #(.DATA_W(DATA_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr), .pc_4(pc_4),
    .id_ready(id_ready), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_br_target(ex_br_target), .ex_jump_dest(ex_jump_dest)
  );

  always #5 clk = ~clk;

  // Reference register file driven from the bench's own write-back stimulus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regModel[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regModel[wb_addr] <= wb_data;
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] readModel(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && (wb_addr == idx)) return wb_data;
    return regModel[idx];
  endfunction

  function automatic expT predict(input logic [31:0] ins, input logic [31:0] pc4);
    expT e;
    logic [5:0] op;
    op       = ins[31:26];
    e.valid  = 1'b1;
    e.opcode = op;
    e.rd     = ins[15:11];
    e.r1     = readModel(ins[25:21]);
    e.r2     = readModel(ins[20:16]);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0000, ins[15:0]};
    else e.imm = {{16{ins[15]}}, ins[15:0]};
    e.br  = pc4 + {e.imm[29:0], 2'b00};
    e.jmp = {pc4[31:28], ins[25:0], 2'b00};
    return e;
  endfunction

  function automatic expT bubble();
    expT e;
    e.valid = 1'b0; e.opcode = '0; e.rd = '0; e.r1 = '0;
    e.r2 = '0; e.imm = '0; e.br = '0; e.jmp = '0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
    id_valid = v;
    instr    = ins;
    pc_4     = pc4;
  endtask

  task automatic test_reset();
    nChecks++;
    if (ex_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
    nChecks++;
    if (ex_imm !== 32'd0 || ex_br_target !== 32'd0 || ex_rdata1 !== 32'd0) begin
      nErrors++; $display("[TB] FAIL reset_data: got imm=%h br=%h r1=%h expected all 0", ex_imm, ex_br_target, ex_rdata1);
    end
    nChecks++;
    if (id_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_ready: got %b expected 1", id_ready); end
  endtask

  task automatic test_writeback();
    expT e;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    wb_we = 1'b0;
    applyStimulus(1'b1, 32'h00A51020, 32'h8);
    sbq.push_back(predict(instr, pc_4));
    tick();
    e = sbq.pop_front();
    nChecks++;
    if (ex_valid !== e.valid || ex_rd !== e.rd || ex_rd !== 5'd2) begin
      nErrors++; $display("[TB] FAIL wb_ctrl: got valid=%b rd=%0d expected valid=1 rd=2", ex_valid, ex_rd);
    end
    nChecks++;
    if (ex_rdata1 !== 32'hDEADBEEF || ex_rdata2 !== 32'hDEADBEEF || ex_rdata1 !== e.r1) begin
      nErrors++; $display("[TB] FAIL wb_data: got r1=%h r2=%h expected deadbeef", ex_rdata1, ex_rdata2);
    end
    nChecks++;
    if (ex_funct !== 6'h20) begin nErrors++; $display("[TB] FAIL wb_funct: got %h expected 20", ex_funct); end
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_bypass();
    expT e;
    logic [31:0] ins [4] = '{32'h00001020, 32'h00001020, 32'h00602020, 32'h00602020};
    logic [31:0] want [4] = '{32'h0, 32'h0, 32'h1234, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      wb_we   = (i == 0) || (i == 2);
      wb_addr = (i == 0) ? 5'd0 : 5'd3;
      wb_data = (i == 0) ? 32'hFFFF : 32'h1234;
      applyStimulus(1'b1, ins[i], 32'h0);
      sbq.push_back(predict(instr, pc_4));
      tick();
      e = sbq.pop_front();
      nChecks++;
      if (ex_rdata1 !== e.r1 || ex_rdata1 !== want[i] || ex_rdata2 !== e.r2 || ex_valid !== 1'b1) begin
        nErrors++; $display("[TB] FAIL bypass_%0d: got r1=%h r2=%h valid=%b expected r1=%h r2=%h", i, ex_rdata1, ex_rdata2, ex_valid, want[i], e.r2);
      end
    end
    wb_we = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_immediate();
    expT e;
    logic [31:0] ins  [7] = '{32'h1000FFFF, 32'h3400FFFF, 32'h08000010, 32'h24000002, 32'h30008000, 32'h20008000, 32'h38008000};
    logic [31:0] pcs  [7] = '{32'h100, 32'h100, 32'h40000004, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0};
    logic [31:0] imms [7] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h10, 32'h2, 32'h8000, 32'hFFFF8000, 32'h8000};
    logic [31:0] brs  [7] = '{32'hFC, 32'h400FC, 32'h40000044, 32'h4, 32'h20000, 32'hFFFE0000, 32'h20000};
    logic [31:0] jmps [7] = '{32'h3FFFC, 32'h3FFFC, 32'h40000040, 32'hF0000008, 32'h20000, 32'h20000, 32'h20000};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, ins[i], pcs[i]);
      e = bubble();
      e.valid = 1'b1; e.opcode = ins[i][31:26]; e.imm = imms[i]; e.br = brs[i]; e.jmp = jmps[i];
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      nChecks++;
      if (ex_valid !== e.valid || ex_opcode !== e.opcode || ex_imm !== e.imm || ex_br_target !== e.br || ex_jump_dest !== e.jmp) begin
        nErrors++;
        $display("[TB] FAIL imm_%0d: got v=%b op=%h imm=%h br=%h jmp=%h expected op=%h imm=%h br=%h jmp=%h",
                 i, ex_valid, ex_opcode, ex_imm, ex_br_target, ex_jump_dest, e.opcode, e.imm, e.br, e.jmp);
      end
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_load_use();
    expT e;
    logic [31:0] lws  [2] = '{32'h8C040000, 32'h8C000000};
    logic [31:0] adds [2] = '{32'h00841020, 32'h00001020};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, lws[k], 32'h0);
      sbq.push_back(predict(instr, pc_4));
      tick();
      e = sbq.pop_front();
      nChecks++;
      if (ex_valid !== 1'b1 || ex_opcode !== e.opcode) begin
        nErrors++; $display("[TB] FAIL lu_load_%0d: got v=%b op=%h expected v=1 op=23", k, ex_valid, ex_opcode);
      end
      applyStimulus(1'b1, adds[k], 32'h0);
      #1;
      nChecks++;
      if (id_ready !== (k == 1)) begin
        nErrors++; $display("[TB] FAIL lu_ready_%0d: got %b expected %b", k, id_ready, (k == 1));
      end
      if (k == 0) begin
        sbq.push_back(bubble());
        tick();
        e = sbq.pop_front();
        nChecks++;
        if (ex_valid !== e.valid) begin nErrors++; $display("[TB] FAIL lu_bubble: got %b expected 0", ex_valid); end
        nChecks++;
        if (id_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL lu_release: got %b expected 1", id_ready); end
      end
      sbq.push_back(predict(instr, pc_4));
      tick();
      e = sbq.pop_front();
      nChecks++;
      if (ex_valid !== 1'b1 || ex_opcode !== e.opcode || ex_rd !== 5'd2) begin
        nErrors++; $display("[TB] FAIL lu_issue_%0d: got v=%b op=%h rd=%0d expected v=1 op=0 rd=2", k, ex_valid, ex_opcode, ex_rd);
      end
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_stall_flush();
    expT e;
    applyStimulus(1'b1, 32'h3405ABCD, 32'h0);
    sbq.push_back(predict(instr, pc_4));
    tick();
    e = sbq.pop_front();
    nChecks++;
    if (ex_valid !== 1'b1 || ex_imm !== e.imm || ex_rd !== e.rd) begin
      nErrors++; $display("[TB] FAIL sf_load: got v=%b imm=%h rd=%0d expected v=1 imm=%h rd=%0d", ex_valid, ex_imm, ex_rd, e.imm, e.rd);
    end
    ex_stall = 1'b1;
    applyStimulus(1'b1, 32'h34E61111, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++;
      if (id_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL stall_ready_%0d: got %b expected 0", i, id_ready); end
      if (i == 1) begin wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55AA; end
      tick();
      wb_we = 1'b0;
      nChecks++;
      if (ex_valid !== 1'b1 || ex_imm !== 32'hABCD || ex_rt !== 5'd5) begin
        nErrors++; $display("[TB] FAIL stall_hold_%0d: got v=%b imm=%h rt=%0d expected v=1 imm=0000abcd rt=5", i, ex_valid, ex_imm, ex_rt);
      end
    end
    ex_stall = 1'b0;
    sbq.push_back(predict(instr, pc_4));
    tick();
    e = sbq.pop_front();
    nChecks++;
    if (ex_rdata1 !== e.r1 || ex_rdata1 !== 32'h55AA || ex_imm !== 32'h1111) begin
      nErrors++; $display("[TB] FAIL stall_reread: got r1=%h imm=%h expected r1=000055aa imm=00001111", ex_rdata1, ex_imm);
    end
    applyStimulus(1'b1, 32'h34081234, 32'h0);
    ex_stall = 1'b1;
    flush    = 1'b1;
    #1;
    nChecks++;
    if (id_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL flush_ready: got %b expected 1", id_ready); end
    tick();
    nChecks++;
    if (ex_valid !== 1'b0 || ex_imm !== 32'h1111) begin
      nErrors++; $display("[TB] FAIL flush_slot: got v=%b imm=%h expected v=0 imm=00001111", ex_valid, ex_imm);
    end
    flush = 1'b0;
    ex_stall = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_async_reset();
    expT e;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
    tick();
    wb_we = 1'b0;
    applyStimulus(1'b1, 32'h01200020, 32'h0);
    sbq.push_back(predict(instr, pc_4));
    tick();
    e = sbq.pop_front();
    nChecks++;
    if (ex_valid !== 1'b1 || ex_rdata1 !== e.r1 || ex_rdata1 !== 32'h77) begin
      nErrors++; $display("[TB] FAIL ar_before: got v=%b r1=%h expected v=1 r1=00000077", ex_valid, ex_rdata1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (ex_valid !== 1'b0 || ex_rdata1 !== 32'd0) begin
      nErrors++; $display("[TB] FAIL ar_clear: got v=%b r1=%h expected v=0 r1=0", ex_valid, ex_rdata1);
    end
    nChecks++;
    if (id_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL ar_ready: got %b expected 1", id_ready); end
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h01250020, 32'h0);
    sbq.push_back(predict(instr, pc_4));
    tick();
    e = sbq.pop_front();
    nChecks++;
    if (ex_valid !== 1'b1 || ex_rdata1 !== e.r1 || ex_rdata2 !== e.r2 || ex_rdata1 !== 32'd0 || ex_rdata2 !== 32'd0) begin
      nErrors++; $display("[TB] FAIL ar_regs: got v=%b r1=%h r2=%h expected v=1 r1=0 r2=0", ex_valid, ex_rdata1, ex_rdata2);
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 32; i++) regModel[i] = '0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_writeback();
    test_bypass();
    test_immediate();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
